// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage feeding the main control decoder. Owns the PC,
//   issues one instruction-memory read at a time (req/ready, then rvalid),
//   holds the returned word and offers it downstream with valid/ready. On
//   accept, the next PC is chosen from the jump / branch-taken outcome that
//   decode/execute report for the held instruction.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   imem_req/imem_addr        read request and address (= pc)
//   imem_ready                memory accepts the request this cycle
//   imem_rvalid/imem_rdata    read response
//   instr_valid/instr_ready   downstream handshake for the held instruction
//   instr, op, pc, pcplus4    held word, its op field, its address, address+4
//   jump, branch_taken        control outcome, sampled only on accept
//   instr_count               accepted-instruction counter (wraps)
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcplus4,
  input  logic              jump,
  input  logic              branch_taken,
  output logic [31:0]       instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       count_q, count_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_tgt;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] next_pc;

  // Target computation (all modulo 2^ADDR_W). Jump keeps the upper nibble
  // of pc+4 and splices in the 26-bit word index; branch adds the
  // sign-extended word offset to pc+4. Jump wins over branch.
  always_comb begin
    pc_inc     = pc_q + ADDR_W'(4);
    jump_tgt   = {pc_inc[ADDR_W-1:28], instr_q[25:0], 2'b00};
    branch_tgt = pc_inc + {{(ADDR_W-18){instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump)              next_pc = jump_tgt;
    else if (branch_taken) next_pc = branch_tgt;
    else                   next_pc = pc_inc;
  end

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    unique case (state_q)
      S_FETCH: begin
        // A response without imem_ready in the same cycle is not ours.
        if (imem_ready) begin
          if (imem_rvalid) begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc;
          count_d = count_q + 32'd1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values computed above, independent of order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  // Handshake outputs are forced low while reset_n is held, since the state
  // register already reads FETCH after the first reset edge.
  assign imem_req    = reset_n && (state_q == S_FETCH);
  assign instr_valid = reset_n && (state_q == S_HOLD);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pcplus4     = pc_inc;
  assign instr       = instr_q;
  assign op          = instr_q[31:26];
  assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A small memory driver returns words with
//   a chosen latency; each issued word and its address are pushed to a
//   scoreboard and popped when the stage presents a valid instruction.
//   Next-PC expectations are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        jump;
  logic        branch_taken;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_instr[$];
  logic [31:0] sb_pc[$];
  logic [31:0] cur_instr;
  logic [31:0] cur_pc;
  logic [31:0] exp_count;

  instr_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .op           (op),
    .pc           (pc),
    .pcplus4      (pcplus4),
    .jump         (jump),
    .branch_taken (branch_taken),
    .instr_count  (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Issue one fetch at addr, returning data after lat cycles (0 = same
  // cycle as ready), after stall cycles of imem_ready=0. Then wait (bounded)
  // for instr_valid and compare against the scoreboard.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input int lat, input int stall);
    int n;
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, addr);
    for (int i = 0; i < stall; i++) begin
      imem_ready = 1'b0;
      step();
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", imem_addr, addr);
    end
    imem_ready  = 1'b1;
    imem_rvalid = (lat == 0);
    imem_rdata  = data;
    sb_instr.push_back(data);
    sb_pc.push_back(addr);
    step();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hBAD0_BAD0;
    if (lat > 0) begin
      for (int i = 1; i < lat; i++) begin
        check("wait_req", {31'd0, imem_req}, 32'd0);
        step();
      end
      check("wait_req", {31'd0, imem_req}, 32'd0);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = data;
      step();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hBAD0_BAD0;
    end
    n = 0;
    while (!instr_valid && n < 8) begin
      step();
      n++;
    end
    check("instr_valid", {31'd0, instr_valid}, 32'd1);
    cur_instr = sb_instr.pop_front();
    cur_pc    = sb_pc.pop_front();
    check("instr", instr, cur_instr);
    check("op", {26'd0, op}, {26'd0, cur_instr[31:26]});
    check("pc", pc, cur_pc);
    check("pcplus4", pcplus4, cur_pc + 32'd4);
  endtask

  // Hold the instruction for hold cycles (with garbage on jump/branch),
  // then accept with the given control outcome.
  task automatic accept(input logic jmp, input logic br, input int hold);
    instr_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      jump         = 1'b1;
      branch_taken = 1'b1;
      step();
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_instr", instr, cur_instr);
      check("hold_op", {26'd0, op}, {26'd0, cur_instr[31:26]});
      check("hold_pc", pc, cur_pc);
      check("hold_req", {31'd0, imem_req}, 32'd0);
      check("hold_count", instr_count, exp_count);
    end
    instr_ready  = 1'b1;
    jump         = jmp;
    branch_taken = br;
    step();
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    exp_count    = exp_count + 32'd1;
    check("accept_count", instr_count, exp_count);
    check("accept_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    reset_n      = 1'b0;
    imem_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    instr_ready  = 1'b0;
    jump         = 1'b0;
    branch_taken = 1'b0;
    exp_count    = 32'd0;

    // Reset held two cycles; everything reads zero.
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_op", {26'd0, op}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    step();
    reset_n = 1'b1;
    step();

    // Sequential fetch, 1-cycle memory latency, immediate accept.
    fetch(32'h0000_0000, 32'h8C01_0004, 1, 0);
    accept(1'b0, 1'b0, 0);
    fetch(32'h0000_0004, 32'h0022_1820, 1, 0);
    accept(1'b0, 1'b0, 0);
    fetch(32'h0000_0008, 32'hAC03_0008, 1, 0);
    accept(1'b0, 1'b0, 0);
    check("count_after_3", instr_count, 32'd3);

    // Branch at 0x10 with imm=-2: taken -> 0x0C, not taken -> 0x14.
    fetch(32'h0000_000C, 32'h0000_0000, 1, 0);
    accept(1'b0, 1'b0, 0);
    fetch(32'h0000_0010, 32'h1000_FFFE, 1, 0);
    accept(1'b0, 1'b1, 0);
    // Backpressure: 5 held cycles, accept on the 6th.
    fetch(32'h0000_000C, 32'h0000_0000, 2, 0);
    accept(1'b0, 1'b0, 5);
    fetch(32'h0000_0010, 32'h1000_FFFE, 1, 0);
    accept(1'b0, 1'b0, 0);

    // Jump to 0 from 0x14, then branch imm=-3 from 0 -> 0xFFFF_FFF8.
    fetch(32'h0000_0014, 32'h0800_0000, 1, 0);
    accept(1'b1, 1'b0, 0);
    fetch(32'h0000_0000, 32'h1000_FFFD, 1, 0);
    accept(1'b0, 1'b1, 0);

    // Zero-latency with 3 stall cycles; jump beats branch and keeps the
    // upper nibble of pc+4 (0xFFFF_FFFC) -> 0xF000_0400.
    fetch(32'hFFFF_FFF8, 32'h0800_0100, 0, 3);
    accept(1'b1, 1'b1, 0);

    // Mid-operation reset while in WAIT, then a stale response.
    check("pre_rst_addr", imem_addr, 32'hF000_0400);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("mid_wait_req", {31'd0, imem_req}, 32'd0);
    reset_n = 1'b0;
    step();
    check("mid_rst_req", {31'd0, imem_req}, 32'd0);
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_count", instr_count, 32'd0);
    exp_count   = 32'd0;
    reset_n     = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    check("stale_valid", {31'd0, instr_valid}, 32'd0);
    check("stale_req", {31'd0, imem_req}, 32'd1);
    check("stale_instr", instr, 32'h0);

    // Restart at RESET_PC, branch to 0xFFFF_FFFC, then wrap to 0.
    fetch(32'h0000_0000, 32'h1000_FFFE, 2, 0);
    accept(1'b0, 1'b1, 0);
    fetch(32'hFFFF_FFFC, 32'h0000_0020, 0, 0);
    accept(1'b0, 1'b0, 0);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    check("final_count", instr_count, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
